des_round_engine: RTL and testbench

DES_ROUND_ENGINE -- requirements
Module: des_round_engine

---
 rtl/des_round_engine.sv | 136 +++++++++++++
 tb/tb_des_round_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative DES round engine, 16 rounds, external f-function.
// Key schedule runs on a rotating CD register so only one PC-2 is needed.
module des_round_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic [31:0] f_r,
  output logic [47:0] f_k,
  input  logic [31:0] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Table entries are DES bit numbers (1 = MSB); element for output bit 1 sits at the top index.
  localparam logic [55:0][7:0] PC1_TAB = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [47:0][7:0] PC2_TAB = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int j = 0; j < 56; j++) o[j[5:0]] = k[6'(8'd64 - PC1_TAB[j[5:0]])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd_in);
    logic [47:0] o;
    o = '0;
    for (int j = 0; j < 48; j++) o[j[5:0]] = cd_in[6'(8'd56 - PC2_TAB[j[5:0]])];
    return o;
  endfunction

  function automatic logic [27:0] rol(input logic [27:0] h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic logic [27:0] ror(input logic [27:0] h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  // Shift schedule: single-bit rotation for rounds 1, 2, 9 and 16, double otherwise.
  function automatic logic shift_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  state_t      state;
  logic [31:0] l, r;
  logic [55:0] cd, next_cd, key_cd;
  logic [3:0]  cnt;
  logic        dec;
  logic        sh;

  assign key_cd = pc1(key);
  assign f_r    = r;
  assign f_k    = pc2(cd);

  // Rotation applied after round cnt+1 prepares the subkey for the following round.
  always_comb begin
    sh      = 1'b0;
    next_cd = cd;
    if (dec) begin
      sh      = shift_two(5'd16 - {1'b0, cnt});
      next_cd = {ror(cd[55:28], sh), ror(cd[27:0], sh)};
    end else begin
      sh      = shift_two({1'b0, cnt} + 5'd2);
      next_cd = {rol(cd[55:28], sh), rol(cd[27:0], sh)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      l         <= '0;
      r         <= '0;
      cd        <= '0;
      cnt       <= '0;
      dec       <= 1'b0;
      out_block <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            l        <= in_block[63:32];
            r        <= in_block[31:0];
            dec      <= decrypt;
            cd       <= decrypt ? key_cd
                                : {rol(key_cd[55:28], 1'b0), rol(key_cd[27:0], 1'b0)};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          l   <= r;
          r   <= l ^ f_out;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            out_block <= {l ^ f_out, r};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cd <= next_cd;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - directed bench for des_round_engine with a reference DES f-function.
module tb_des_round_engine;

  logic        clk, rst_n, in_valid, in_ready, decrypt, out_valid, out_ready;
  logic [63:0] in_block, key, out_block;
  logic [31:0] f_r, f_out;
  logic [47:0] f_k;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  des_round_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .key(key), .decrypt(decrypt),
    .f_r(f_r), .f_k(f_k), .f_out(f_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int pc1_t [0:55] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [0:47] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int e_t   [0:47] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                       16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t   [0:31] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int sh_t  [1:16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [63:0] sbox_rows [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [31:0] f_fn(input logic [31:0] rr, input logic [47:0] kk);
    logic [47:0] e, x;
    logic [31:0] s, o;
    logic [5:0]  six;
    logic [63:0] row_v;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = rr[5'(32 - e_t[i])];
    x = e ^ kk;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six   = x[6'(47 - 6 * b) -: 6];
      row_v = sbox_rows[5'(b * 4 + int'({six[5], six[0]}))];
      s[5'(31 - 4 * b) -: 4] = row_v[6'(63 - 4 * int'(six[4:1])) -: 4];
    end
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - p_t[i])];
    return o;
  endfunction

  // Independent reference: precompute all subkeys by cumulative left rotation, then run 16 rounds.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] kk, input logic dd);
    logic [55:0] pc, cdv;
    logic [27:0] c, d;
    logic [47:0] ks [1:16];
    logic [31:0] lv, rv, t;
    for (int j = 0; j < 56; j++) pc[6'(55 - j)] = kk[6'(64 - pc1_t[j])];
    c = pc[55:28];
    d = pc[27:0];
    for (int i = 1; i <= 16; i++) begin
      for (int s = 0; s < sh_t[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cdv = {c, d};
      for (int j = 0; j < 48; j++) ks[i][6'(47 - j)] = cdv[6'(56 - pc2_t[j])];
    end
    lv = blk[63:32];
    rv = blk[31:0];
    for (int i = 1; i <= 16; i++) begin
      t  = lv ^ f_fn(rv, dd ? ks[17 - i] : ks[i]);
      lv = rv;
      rv = t;
    end
    return {rv, lv};
  endfunction

  assign f_out = f_fn(f_r, f_k);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  logic [63:0] blks [0:3];
  logic [63:0] keys [0:3];
  logic [63:0] rb, rk;
  int n, last_acc, acc, w;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; key = '0; decrypt = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_f_r", 64'(f_r), 64'd0);
    chk("rst_f_k", 64'(f_k), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Known encrypt vector, then hold in DONE under backpressure
    key = 64'h133457799BBCDFF1; in_block = 64'hCC00CCFFF0AAF0AA; decrypt = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("enc_in_ready_busy", 64'(in_ready), 64'd0);
    chk("enc_k1", 64'(f_k), 64'h1B02EFFC7072);
    chk("enc_r0", 64'(f_r), 64'hF0AAF0AA);
    repeat (15) tick();
    chk("enc_not_yet_valid", 64'(out_valid), 64'd0);
    tick();
    chk("enc_valid_t16", 64'(out_valid), 64'd1);
    chk("enc_block", out_block, 64'h0A4CD99543423234);

    in_valid = 1'b1; in_block = 64'h0123456789ABCDEF; key = 64'hFFFFFFFFFFFFFFFF; decrypt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_block", out_block, 64'h0A4CD99543423234);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_f_r", 64'(f_r), 64'h0A4CD995);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("hs_out_valid_drop", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_block_held", out_block, 64'h0A4CD99543423234);

    // Known decrypt vector; out_ready held high during the run must not disturb it
    key = 64'h133457799BBCDFF1; in_block = 64'h0A4CD99543423234; decrypt = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("dec_k16", 64'(f_k), 64'hCB3D8B0E17F5);
    chk("dec_r0", 64'(f_r), 64'h43423234);
    wait_out(w);
    chk("dec_latency", 64'(w), 64'd16);
    chk("dec_block", out_block, 64'hCC00CCFFF0AAF0AA);
    tick();
    chk("dec_hs_in_ready", 64'(in_ready), 64'd1);

    // Reset asserted asynchronously after round 8
    rb = {$urandom(), $urandom()}; rk = {$urandom(), $urandom()};
    in_block = rb; key = rk; decrypt = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_f_r", 64'(f_r), 64'd0);
    chk("mid_rst_f_k", 64'(f_k), 64'd0);
    chk("mid_rst_out_block", out_block, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_rst_no_emit", 64'(out_valid), 64'd0);
    rb = {$urandom(), $urandom()}; rk = {$urandom(), $urandom()};
    in_block = rb; key = rk; decrypt = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(w);
    chk("after_rst_valid", 64'(out_valid), 64'd1);
    chk("after_rst_block", out_block, des_model(rb, rk, 1'b1));
    tick();

    // Back-to-back with in_valid and out_ready both held high
    for (int i = 0; i < 4; i++) begin
      blks[i] = {$urandom(), $urandom()};
      keys[i] = {$urandom(), $urandom()};
    end
    last_acc = 0;
    in_block = blks[0]; key = keys[0]; decrypt = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        tick();
        n++;
      end
      chk("b2b_ready_seen", 64'(in_ready), 64'd1);
      tick();
      acc = cyc;
      if (i > 0) chk("b2b_interval", 64'(acc - last_acc), 64'd18);
      last_acc = acc;
      if (i < 3) begin
        in_block = blks[i + 1]; key = keys[i + 1]; decrypt = (i % 2 == 0);
      end else begin
        in_valid = 1'b0;
      end
      wait_out(w);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_block", out_block, des_model(blks[i], keys[i], (i % 2 == 1)));
    end
    tick();
    chk("b2b_final_idle", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
